// File: rtl/svga_timing_generator.sv
// svga_timing_generator
//   800x600@72 Hz SVGA timing and output stage, clocked directly from the 50 MHz system clock.
//   The horizontal and vertical counters are exposed as the current pixel coordinate. Upstream
//   logic returns a color combinationally in the same cycle. That color is registered with
//   blanking applied, and HSYNC/VSYNC are registered alongside it so all three stay aligned.
//
// Ports
//   clk          in   pixel/system clock
//   reset        in   synchronous, active-high reset
//   color_in     in   RGB332 color for (pixel_x, pixel_y), combinational from upstream
//   pixel_x      out  horizontal counter
//   pixel_y      out  vertical counter
//   pixel_valid  out  coordinate lies inside the visible area
//   frame_start  out  one-cycle strobe at counter position (0,0)
//   color_out    out  registered color, forced to 0 during blanking
//   hsync        out  registered horizontal sync
//   vsync        out  registered vertical sync
//
// The registered outputs lag pixel_x/pixel_y by exactly one cycle.

module svga_timing_generator #(
  parameter int unsigned H_VISIBLE   = 800,
  parameter int unsigned H_FRONT     = 56,
  parameter int unsigned H_SYNC      = 120,
  parameter int unsigned H_BACK      = 64,
  parameter int unsigned V_VISIBLE   = 600,
  parameter int unsigned V_FRONT     = 37,
  parameter int unsigned V_SYNC      = 6,
  parameter int unsigned V_BACK      = 23,
  parameter logic        SYNC_ACTIVE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  color_in,
  output logic [10:0] pixel_x,
  output logic [9:0]  pixel_y,
  output logic        pixel_valid,
  output logic        frame_start,
  output logic [7:0]  color_out,
  output logic        hsync,
  output logic        vsync
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Sized copies of the timing points so every compare is width-matched.
  localparam logic [10:0] HLast      = 11'(H_TOTAL - 1);
  localparam logic [10:0] HVisEnd    = 11'(H_VISIBLE);
  localparam logic [10:0] HSyncStart = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HSyncEnd   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]  VLast      = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VVisEnd    = 10'(V_VISIBLE);
  localparam logic [9:0]  VSyncStart = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VSyncEnd   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic        h_wrap;
  logic        in_hsync, in_vsync;
  logic [7:0]  color_q, color_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;

  // Counter next-state: the vertical counter only moves on the horizontal wrap.
  always_comb begin
    h_wrap = (h_q == HLast);
    h_d    = h_wrap ? '0 : h_q + 11'd1;
    v_d    = v_q;
    if (h_wrap) begin
      v_d = (v_q == VLast) ? '0 : v_q + 10'd1;
    end
  end

  // Decode of the current coordinate; drives both the exposed strobes and the output stage.
  always_comb begin
    pixel_valid = (h_q < HVisEnd) && (v_q < VVisEnd);
    frame_start = (h_q == '0) && (v_q == '0) && !reset;
    in_hsync    = (h_q >= HSyncStart) && (h_q < HSyncEnd);
    in_vsync    = (v_q >= VSyncStart) && (v_q < VSyncEnd);
    color_d     = pixel_valid ? color_in : 8'h00;
    hsync_d     = in_hsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d     = in_vsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q     <= '0;
      v_q     <= '0;
      color_q <= 8'h00;
      hsync_q <= ~SYNC_ACTIVE;
      vsync_q <= ~SYNC_ACTIVE;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      color_q <= color_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign pixel_x   = h_q;
  assign pixel_y   = v_q;
  assign color_out = color_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;

endmodule

// File: tb/tb_svga_timing_generator.sv
// Bench for svga_timing_generator.
//   dut_a uses the full 800x600 timing for reset, line timing, pixel color and mid-frame reset.
//   dut_b uses a scaled-down timing (15 clocks x 9 lines) so whole frames, vertical sync and both
//   wrap-arounds can be walked cycle by cycle against a counter model.

module tb_svga_timing_generator;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Full-size instance
  logic        rst_a;
  logic        mode_a;
  logic [7:0]  const_a;
  logic [7:0]  color_in_a;
  logic [10:0] pixel_x_a;
  logic [9:0]  pixel_y_a;
  logic        pixel_valid_a, frame_start_a, hsync_a, vsync_a;
  logic [7:0]  color_out_a;

  // Upstream model: either a constant or the low byte of the current x coordinate.
  assign color_in_a = mode_a ? pixel_x_a[7:0] : const_a;

  svga_timing_generator dut_a (
    .clk         (clk),
    .reset       (rst_a),
    .color_in    (color_in_a),
    .pixel_x     (pixel_x_a),
    .pixel_y     (pixel_y_a),
    .pixel_valid (pixel_valid_a),
    .frame_start (frame_start_a),
    .color_out   (color_out_a),
    .hsync       (hsync_a),
    .vsync       (vsync_a)
  );

  // Scaled instance: H 8/2/3/2 = 15, V 4/2/2/1 = 9, frame = 135 cycles
  logic        rst_b;
  logic [7:0]  color_in_b;
  logic [10:0] pixel_x_b;
  logic [9:0]  pixel_y_b;
  logic        pixel_valid_b, frame_start_b, hsync_b, vsync_b;
  logic [7:0]  color_out_b;

  svga_timing_generator #(
    .H_VISIBLE   (8),
    .H_FRONT     (2),
    .H_SYNC      (3),
    .H_BACK      (2),
    .V_VISIBLE   (4),
    .V_FRONT     (2),
    .V_SYNC      (2),
    .V_BACK      (1),
    .SYNC_ACTIVE (1'b1)
  ) dut_b (
    .clk         (clk),
    .reset       (rst_b),
    .color_in    (color_in_b),
    .pixel_x     (pixel_x_b),
    .pixel_y     (pixel_y_b),
    .pixel_valid (pixel_valid_b),
    .frame_start (frame_start_b),
    .color_out   (color_out_b),
    .hsync       (hsync_b),
    .vsync       (vsync_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One reset edge, then release; counters sit at (0,0) on return.
  task automatic reset_a();
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_a   = 1'b1;
    rst_b   = 1'b1;
    mode_a  = 1'b0;
    const_a = 8'hA5;
    repeat (5) step();
    checks++;
    if (color_out_a !== 8'h00) begin
      fails++; $display("FAIL reset_color: got %0h expected 0", color_out_a);
    end
    checks++;
    if (hsync_a !== 1'b0 || vsync_a !== 1'b0) begin
      fails++; $display("FAIL reset_sync: got hs=%b vs=%b expected 0 0", hsync_a, vsync_a);
    end
    checks++;
    if (frame_start_a !== 1'b0) begin
      fails++; $display("FAIL reset_fs_masked: got %b expected 0", frame_start_a);
    end
    rst_a = 1'b0;
    #1;
    checks++;
    if (pixel_x_a !== 11'd0 || pixel_y_a !== 10'd0) begin
      fails++; $display("FAIL release_xy: got (%0d,%0d) expected (0,0)", pixel_x_a, pixel_y_a);
    end
    checks++;
    if (frame_start_a !== 1'b1) begin
      fails++; $display("FAIL release_fs: got %b expected 1", frame_start_a);
    end
    checks++;
    if (pixel_valid_a !== 1'b1) begin
      fails++; $display("FAIL release_valid: got %b expected 1", pixel_valid_a);
    end
    step();
    checks++;
    if (frame_start_a !== 1'b0 || pixel_x_a !== 11'd1) begin
      fails++; $display("FAIL after_release: got fs=%b x=%0d expected fs=0 x=1",
                        frame_start_a, pixel_x_a);
    end
  endtask

  task automatic test_horizontal();
    int hp;
    logic [7:0] exp_c;
    logic exp_hs;
    mode_a  = 1'b0;
    const_a = 8'hA5;
    reset_a();
    for (int n = 1; n <= 1040; n++) begin
      step();
      hp     = n - 1;
      exp_c  = (hp < 800) ? 8'hA5 : 8'h00;
      exp_hs = (hp >= 856) && (hp < 976);
      checks++;
      if (pixel_x_a !== 11'(n % 1040)) begin
        fails++; $display("FAIL h_count n=%0d: got %0d expected %0d", n, pixel_x_a, n % 1040);
      end
      checks++;
      if (color_out_a !== exp_c) begin
        fails++; $display("FAIL h_color h=%0d: got %0h expected %0h", hp, color_out_a, exp_c);
      end
      checks++;
      if (hsync_a !== exp_hs || vsync_a !== 1'b0) begin
        fails++; $display("FAIL h_sync h=%0d: got hs=%b vs=%b expected hs=%b vs=0",
                          hp, hsync_a, vsync_a, exp_hs);
      end
    end
    checks++;
    if (pixel_x_a !== 11'd0 || pixel_y_a !== 10'd1 || frame_start_a !== 1'b0) begin
      fails++; $display("FAIL line_period: got (%0d,%0d) fs=%b expected (0,1) fs=0",
                        pixel_x_a, pixel_y_a, frame_start_a);
    end
  endtask

  task automatic test_pixel_color();
    int hp;
    logic [7:0] exp_c;
    mode_a = 1'b1;
    reset_a();
    for (int n = 1; n <= 801; n++) begin
      step();
      hp    = n - 1;
      exp_c = (hp < 800) ? 8'(hp % 256) : 8'h00;
      checks++;
      if (color_out_a !== exp_c) begin
        fails++; $display("FAIL pix_color h=%0d: got %0h expected %0h", hp, color_out_a, exp_c);
      end
    end
    mode_a = 1'b0;
  endtask

  task automatic test_mid_reset();
    mode_a  = 1'b0;
    const_a = 8'h5A;
    reset_a();
    repeat (400) step();
    checks++;
    if (pixel_x_a !== 11'd400) begin
      fails++; $display("FAIL mid_pre: got x=%0d expected 400", pixel_x_a);
    end
    rst_a = 1'b1;
    step();
    checks++;
    if (pixel_x_a !== 11'd0 || pixel_y_a !== 10'd0 || color_out_a !== 8'h00) begin
      fails++; $display("FAIL mid_reset: got (%0d,%0d) c=%0h expected (0,0) c=0",
                        pixel_x_a, pixel_y_a, color_out_a);
    end
    rst_a = 1'b0;
    #1;
    checks++;
    if (frame_start_a !== 1'b1) begin
      fails++; $display("FAIL mid_fs: got %b expected 1", frame_start_a);
    end
    step();
    checks++;
    if (color_out_a !== 8'h5A || hsync_a !== 1'b0 || vsync_a !== 1'b0) begin
      fails++; $display("FAIL mid_out: got c=%0h hs=%b vs=%b expected c=5a hs=0 vs=0",
                        color_out_a, hsync_a, vsync_a);
    end
    checks++;
    if (pixel_x_a !== 11'd1 || frame_start_a !== 1'b0) begin
      fails++; $display("FAIL mid_next: got x=%0d fs=%b expected x=1 fs=0",
                        pixel_x_a, frame_start_a);
    end
    repeat (1039) step();
    checks++;
    if (pixel_x_a !== 11'd0 || pixel_y_a !== 10'd1) begin
      fails++; $display("FAIL mid_resume: got (%0d,%0d) expected (0,1)", pixel_x_a, pixel_y_a);
    end
  endtask

  // Two frames on the scaled instance, every output compared each cycle.
  task automatic test_frame_small();
    int h, v, ph, pv;
    int fs_count, fs_first, fs_last, vs_high;
    logic [7:0] exp_c;
    logic exp_valid, exp_hs, exp_vs;
    color_in_b = 8'h3C;
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    #1;
    fs_count = 0;
    fs_first = -1;
    fs_last  = -1;
    vs_high  = 0;
    if (frame_start_b === 1'b1) begin
      fs_count = 1; fs_first = 0; fs_last = 0;
    end
    for (int n = 1; n <= 269; n++) begin
      step();
      h  = n % 15;
      v  = (n / 15) % 9;
      ph = (n - 1) % 15;
      pv = ((n - 1) / 15) % 9;
      exp_valid = (h < 8) && (v < 4);
      exp_c     = ((ph < 8) && (pv < 4)) ? 8'h3C : 8'h00;
      exp_hs    = (ph >= 10) && (ph < 13);
      exp_vs    = (pv >= 6) && (pv < 8);
      if (frame_start_b === 1'b1) begin
        fs_count++;
        if (fs_first < 0) fs_first = n;
        fs_last = n;
      end
      if (n <= 135 && vsync_b === 1'b1) vs_high++;
      checks++;
      if (pixel_x_b !== 11'(h) || pixel_y_b !== 10'(v)) begin
        fails++; $display("FAIL b_xy n=%0d: got (%0d,%0d) expected (%0d,%0d)",
                          n, pixel_x_b, pixel_y_b, h, v);
      end
      checks++;
      if (pixel_valid_b !== exp_valid) begin
        fails++; $display("FAIL b_valid n=%0d: got %b expected %b", n, pixel_valid_b, exp_valid);
      end
      checks++;
      if (frame_start_b !== ((h == 0) && (v == 0))) begin
        fails++; $display("FAIL b_fs n=%0d: got %b expected %b", n, frame_start_b,
                          (h == 0) && (v == 0));
      end
      checks++;
      if (color_out_b !== exp_c) begin
        fails++; $display("FAIL b_color (%0d,%0d): got %0h expected %0h",
                          ph, pv, color_out_b, exp_c);
      end
      checks++;
      if (hsync_b !== exp_hs) begin
        fails++; $display("FAIL b_hsync (%0d,%0d): got %b expected %b", ph, pv, hsync_b, exp_hs);
      end
      checks++;
      if (vsync_b !== exp_vs) begin
        fails++; $display("FAIL b_vsync (%0d,%0d): got %b expected %b", ph, pv, vsync_b, exp_vs);
      end
    end
    checks++;
    if (fs_count != 2 || fs_first != 0 || fs_last != 135) begin
      fails++; $display("FAIL b_fs_count: got %0d pulses at %0d,%0d expected 2 at 0,135",
                        fs_count, fs_first, fs_last);
    end
    checks++;
    if (vs_high != 30) begin
      fails++; $display("FAIL b_vsync_width: got %0d cycles expected 30", vs_high);
    end
  endtask

  initial begin
    rst_a      = 1'b1;
    rst_b      = 1'b1;
    mode_a     = 1'b0;
    const_a    = 8'h00;
    color_in_b = 8'h00;
    test_reset();
    test_horizontal();
    test_pixel_color();
    test_mid_reset();
    test_frame_small();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
